logit_sar: RTL and testbench
============================

Name: logit_sar

Overview:
- Inverse of the team's Q8.8 sigmoid approximator: takes a probability y (Q8.8, unsigned) and returns x (Q8.8, signed) such that sigmoid(x) ≈ y.
- Computes x by successive approximation, one bit per clock, over a monotone piecewise forward model (sigmoid_eval).
- Sits behind a valid/ready input and a valid/ready output, for use in pin-limited top levels where 16-bit operands are split across ui_in/uio_in.

Parameters:
- XW, 12: search width. x range is [-2^(XW-1), 2^(XW-1)-1] LSBs of Q8.8, i.e. -8.0..+7.996 at the default. Legal range 10..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  y_in valid
- in_ready  out  1  block idle, can accept
- y_in  in  16  probability, unsigned Q8.8 (0x0100 = 1.0)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- x_out  out  16  result, signed Q8.8, sign-extended from XW bits
- sat  out  1  y_in outside open interval (0,1): y_in==0 or y_in>=0x0100

Behaviour:
- Forward model sigmoid_eval(x), with x signed 16-bit and a = |x|:
  - n = a[14:8], f = a[7:0].
  - t = (0x80 - (f>>2)) >> n, with t = 0 when n >= 16.
  - sigma = 0x100 - t for x >= 0; sigma = t for x < 0.
  - The model is non-decreasing in x. At x = 0, sigma = 0x80.
- Result: the smallest x in the range with sigma(x) >= y_in. If no x qualifies, the result is 2^(XW-1)-1.
- Search is a lower-bound SAR:
  - On accept: lo = -2^(XW-1), k = XW-1.
  - Each SEARCH cycle: cand = lo + 2^k - 1. If sigma(cand) < y, then lo = cand + 1. Then k decrements.
  - lo is held in XW+1 bits. The final value lo = 2^(XW-1) is clamped to 2^(XW-1)-1.
- FSM states: IDLE, SEARCH, DONE (plus FIX under the optional feature).
  - IDLE: in_ready = 1. On in_valid && in_ready, latch y_in and compute sat → SEARCH.
  - SEARCH: one iteration per clock. After the k==0 iteration → DONE.
  - DONE: out_valid = 1; x_out and sat held stable. On out_ready → IDLE.
- in_ready is low in every state except IDLE. The block holds no second transaction; there is no overlap.
- Latency: out_valid rises XW rising edges after the accepting edge (12 at default). Throughput is one result per XW+2 cycles minimum.
- out_valid && out_ready in DONE returns to IDLE. in_ready rises on the next cycle, so there is no same-cycle re-accept.
- Reset (async, any state): state = IDLE and all registers clear. Outputs: in_ready = 1, out_valid = 0, x_out = 0, sat = 0. Any in-flight transaction is dropped silently.
- y_in and in_valid are ignored outside IDLE. x_out changes only on the DONE entry edge.

Optional Feature:
- Macro LOGIT_NEAREST_EN.
- Defined:
  - After SEARCH the FSM enters FIX for one cycle, then DONE. Latency becomes XW+1.
  - In FIX, if lo > min and (y - sigma(lo-1)) < (sigma(lo) - y), the result is lo-1; otherwise lo. Ties keep lo.
- Undefined: no FIX state; the result is the lower-bound value.

Decomposition:
- Package logit_pkg holds:
  - Q8.8 constants: Q_ONE = 16'h0100, Q_HALF = 16'h0080.
  - State enum: IDLE, SEARCH, FIX, DONE.
- Sub-module sigmoid_eval: purely combinational forward model (x[15:0] → sigma[15:0]).
  - Instanced once in logit_sar; under LOGIT_NEAREST_EN its input is muxed between cand and lo-1.
  - Also reusable as a golden model in the bench.

Test Plan:
- y_in = 0x0080 → x_out = 0xFFFD (-3 LSB; sigma(-3) = 0x80, sigma(-4) = 0x7F), sat = 0, out_valid exactly 12 edges after accept.
- y_in = 0x00C0 → x_out = 0x0100; y_in = 0x0040 → x_out = 0xFEFD; sat = 0 in both.
- y_in = 0x0000 → x_out = 0xF800, sat = 1. y_in = 0x0100 → 0x0704, sat = 1. y_in = 0x0200 → 0x07FF (clamped), sat = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → x_out and out_valid stable, in_ready = 0. Any in_valid pulses in that window are ignored; the next accept occurs only after IDLE.
- Assert rst_n low mid-SEARCH (iteration 5) → immediately out_valid = 0, x_out = 0, in_ready = 1. A fresh y_in = 0x00C0 then yields 0x0100 normally.
- Exhaustive sweep of y_in 0x0000..0x0101 against the sigmoid_eval golden model. Check minimality: sigma(x_out) >= y, and sigma(x_out-1) < y when x_out > min. Repeat with LOGIT_NEAREST_EN defined, checking the nearest rule and latency 13.

Source files
------------

// File: rtl/logit_pkg.sv
// logit_pkg: shared Q8.8 constants and FSM state encoding for the logit_sar block.
`default_nettype none

package logit_pkg;

  localparam logic [15:0] Q_ONE  = 16'h0100;
  localparam logic [15:0] Q_HALF = 16'h0080;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FIX    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sigmoid_eval.sv
// sigmoid_eval: combinational piecewise Q8.8 sigmoid, monotone in x, sigma(0) = 0x80.
`default_nettype none

module sigmoid_eval
  import logit_pkg::*;
(
  input  logic [15:0] x,
  output logic [15:0] sigma
);

  logic [15:0] a;
  logic [6:0]  n;
  logic [7:0]  f;
  logic [15:0] base;
  logic [15:0] t;

  always_comb begin
    a     = x[15] ? (~x + 16'd1) : x;
    n     = a[14:8];
    f     = a[7:0];
    base  = Q_HALF - {10'd0, f[7:2]};
    t     = (n >= 7'd16) ? 16'd0 : (base >> n);
    sigma = x[15] ? t : (Q_ONE - t);
  end

endmodule

`default_nettype wire

// File: rtl/logit_sar.sv
// logit_sar: inverse Q8.8 sigmoid by lower-bound successive approximation, one bit per clock.
// Optional LOGIT_NEAREST_EN adds a FIX cycle that rounds the result to the nearer of lo-1 / lo.
`default_nettype none

module logit_sar
  import logit_pkg::*;
#(
  parameter int XW = 12
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] x_out,
  output logic        sat
);

  localparam int         LW      = XW + 1;
  localparam logic [LW-1:0] LO_MIN  = {2'b11, {(XW-1){1'b0}}};
  localparam logic [LW-1:0] LO_MAX  = {2'b00, {(XW-1){1'b1}}};
  localparam logic [LW-1:0] LO_OVER = {2'b01, {(XW-1){1'b0}}};
  localparam logic [3:0]    K_TOP   = 4'(XW - 1);

  state_t        state;
  state_t        state_nx;
  logic [15:0]   y;
  logic [LW-1:0] lo;
  logic [LW-1:0] cand;
  logic [LW-1:0] lo_raw;
  logic [LW-1:0] lo_nx;
  logic [3:0]    k;
  logic [15:0]   eval_x;
  logic [15:0]   eval_sigma;
  logic          pass;

  assign cand = lo + (LW'(1) << k) - LW'(1);

`ifdef LOGIT_NEAREST_EN
  logic [LW-1:0] lo_dn;
  logic [15:0]   sig_hi;
  logic          found;
  logic          pick_dn;

  // In FIX the shared evaluator looks one step below lo; sigma(lo) was captured during SEARCH.
  assign lo_dn   = lo - LW'(1);
  assign eval_x  = (state == FIX) ? 16'(signed'(lo_dn)) : 16'(signed'(cand));
  assign pick_dn = found && (lo != LO_MIN) &&
                   (({1'b0, y} - {1'b0, eval_sigma}) < ({1'b0, sig_hi} - {1'b0, y}));
`else
  assign eval_x  = 16'(signed'(cand));
`endif

  sigmoid_eval u_eval (
    .x     (eval_x),
    .sigma (eval_sigma)
  );

  assign pass   = (eval_sigma >= y);
  assign lo_raw = pass ? lo : (cand + LW'(1));
  // Only the final step can land one past the range; that means no x qualified.
  assign lo_nx  = (lo_raw == LO_OVER) ? LO_MAX : lo_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SEARCH;
      end
      SEARCH: begin
        if (k == 4'd0) begin
`ifdef LOGIT_NEAREST_EN
          state_nx = FIX;
`else
          state_nx = DONE;
`endif
        end
      end
      FIX:  state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y      <= '0;
      sat    <= 1'b0;
      lo     <= '0;
      k      <= '0;
      x_out  <= '0;
`ifdef LOGIT_NEAREST_EN
      sig_hi <= '0;
      found  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y   <= y_in;
            sat <= (y_in == 16'd0) || (y_in >= Q_ONE);
            lo  <= LO_MIN;
            k   <= K_TOP;
`ifdef LOGIT_NEAREST_EN
            sig_hi <= '0;
            found  <= 1'b0;
`endif
          end
        end
        SEARCH: begin
          lo <= lo_nx;
          k  <= k - 4'd1;
`ifdef LOGIT_NEAREST_EN
          // The last passing candidate is the final lower bound, so its sigma is sigma(lo).
          if (pass) begin
            found  <= 1'b1;
            sig_hi <= eval_sigma;
          end
`else
          if (k == 4'd0) x_out <= 16'(signed'(lo_nx));
`endif
        end
`ifdef LOGIT_NEAREST_EN
        FIX: x_out <= 16'(signed'(pick_dn ? lo_dn : lo));
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_logit_sar.sv
// tb_logit_sar: directed and swept self-checking bench for logit_sar (either build of LOGIT_NEAREST_EN).
`default_nettype none

module tb_logit_sar;

  localparam int XW   = 12;
  localparam int XMIN = -(2 ** (XW - 1));
  localparam int XMAX = (2 ** (XW - 1)) - 1;
`ifdef LOGIT_NEAREST_EN
  localparam int LAT  = XW + 1;
`else
  localparam int LAT  = XW;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] y_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] x_out;
  logic        sat;

  int n_checks = 0;
  int n_pass   = 0;

  logit_sar #(.XW(XW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int sig_ref(input int x);
    int a, n, f, t;
    a = (x < 0) ? -x : x;
    n = a >> 8;
    f = a & 255;
    t = (n >= 16) ? 0 : ((128 - (f >> 2)) >> n);
    return (x >= 0) ? 256 - t : t;
  endfunction

  function automatic int x_ref(input int y);
    int r;
    bit found;
    r = XMAX;
    found = 1'b0;
    for (int x = XMIN; x <= XMAX; x++) begin
      if (!found && sig_ref(x) >= y) begin
        r = x;
        found = 1'b1;
      end
    end
`ifdef LOGIT_NEAREST_EN
    if (found && r > XMIN && (y - sig_ref(r - 1)) < (sig_ref(r) - y)) r = r - 1;
`endif
    return r;
  endfunction

  task automatic start_txn(input logic [15:0] y);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    y_in     = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("ret_idle_ready", 32'(in_ready), 32'd1);
    check("ret_idle_valid", 32'(out_valid), 32'd0);
  endtask

  logic [15:0] dir_y   [6] = '{16'h0080, 16'h00C0, 16'h0040, 16'h0000, 16'h0100, 16'h0200};
  logic [15:0] dir_x   [6] = '{16'hFFFD, 16'h0100, 16'hFEFD, 16'hF800, 16'h0704, 16'h07FF};
  logic        dir_sat [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int lat;
    int xs;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_x_out",     32'(x_out),     32'd0);
    check("rst_sat",       32'(sat),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start_txn(dir_y[i]);
      check("dir_busy", 32'(in_ready), 32'd0);
      wait_valid(lat);
      check("dir_latency", 32'(lat), 32'(LAT));
      check("dir_x", 32'(x_out), 32'(dir_x[i]));
      check("dir_sat", 32'(sat), 32'(dir_sat[i]));
      release_out();
    end

    // Backpressure: hold the result while stray requests arrive.
    start_txn(16'h0040);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = c[0];
      y_in     = 16'h00C0;
      @(posedge clk);
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_x", 32'(x_out), 32'h0000FEFD);
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    start_txn(16'h0080);
    wait_valid(lat);
    check("post_bp_x", 32'(x_out), 32'h0000FFFD);
    release_out();

    // Asynchronous reset in the middle of a search.
    start_txn(16'h0040);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_x", 32'(x_out), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    start_txn(16'h00C0);
    wait_valid(lat);
    check("post_rst_lat", 32'(lat), 32'(LAT));
    check("post_rst_x", 32'(x_out), 32'h00000100);
    release_out();

    for (int y = 0; y <= 16'h0101; y++) begin
      start_txn(16'(y));
      wait_valid(lat);
      xs = int'($signed(x_out));
      check("sweep_lat", 32'(lat), 32'(LAT));
      check("sweep_x", 32'(xs), 32'(x_ref(y)));
      check("sweep_sat", 32'(sat), 32'((y == 0) || (y >= 256)));
`ifndef LOGIT_NEAREST_EN
      if (y <= 256) check("sweep_ge", 32'(sig_ref(xs) >= y), 32'd1);
      if (xs > XMIN) check("sweep_min", 32'(sig_ref(xs - 1) < y), 32'd1);
`endif
      release_out();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
